// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage between the execute stage and the data memory.
//
// Accepts one request per transaction (valid/ready), drives the memory port from
// registers for exactly one cycle, captures and extends the returned lane, and
// holds the response until it is consumed. Misaligned requests skip memory
// entirely and answer one edge after acceptance.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready    request handshake; ready only while idle
//   req_wen, req_size        1=store / 0=load; size 0=byte 1=half 2=word 3=double
//   req_unsigned             zero-extend loads (sizes 0..2)
//   req_addr, req_wdata      byte address, low-aligned store data
//   req_rd                   destination tag, echoed on resp_rd
//   resp_valid / resp_ready  response handshake
//   resp_rdata               extended load data, 0 for stores and misaligned
//   resp_rd, resp_misalign   echoed tag, misalignment flag
//   mem_ena, mem_wen         memory enable / write enable
//   mem_mask                 one-hot size: [0]=double [1]=word [2]=half [3]=byte
//   mem_addr                 byte address, PARK_ADDR while mem_ena=0
//   mem_wdata                store data replicated across lanes of its size
//   mem_rdata                raw doubleword, valid the cycle after the access edge
//
// State   | meaning
// IDLE    | waiting for a request, req_ready=1
// ISSUE   | memory port enabled for one cycle
// WAIT    | memory data returning, capture and extend
// RESP    | response held until resp_ready

module lsu_ctrl #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] PARK_ADDR = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [4:0]      resp_rd,
    output logic            resp_misalign,
    output logic            mem_ena,
    output logic            mem_wen,
    output logic [3:0]      mem_mask,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            wen_q, wen_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [2:0]      lane_q, lane_d;
    logic [4:0]      rd_q, rd_d;

    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic            resp_misalign_q, resp_misalign_d;
    logic            mem_ena_q, mem_ena_d;
    logic            mem_wen_q, mem_wen_d;
    logic [3:0]      mem_mask_q, mem_mask_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic            misalign;
    logic [3:0]      size_onehot;
    logic [XLEN-1:0] wdata_repl;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            2'd3:    misalign = |req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        size_onehot = 4'b0000;
        wdata_repl  = req_wdata;
        case (req_size)
            2'd0: begin
                size_onehot = 4'b1000;
                wdata_repl  = {8{req_wdata[7:0]}};
            end
            2'd1: begin
                size_onehot = 4'b0100;
                wdata_repl  = {4{req_wdata[15:0]}};
            end
            2'd2: begin
                size_onehot = 4'b0010;
                wdata_repl  = {2{req_wdata[31:0]}};
            end
            default: begin
                size_onehot = 4'b0001;
                wdata_repl  = req_wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend from its top bit.
    always_comb begin
        shifted  = mem_rdata >> {lane_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0:    load_ext = {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
            2'd2:    load_ext = {{(XLEN-32){~uns_q & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        wen_d           = wen_q;
        size_d          = size_q;
        uns_d           = uns_q;
        lane_d          = lane_q;
        rd_d            = rd_q;
        resp_valid_d    = resp_valid_q;
        resp_rdata_d    = resp_rdata_q;
        resp_rd_d       = resp_rd_q;
        resp_misalign_d = resp_misalign_q;
        mem_ena_d       = mem_ena_q;
        mem_wen_d       = mem_wen_q;
        mem_mask_d      = mem_mask_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wen_d  = req_wen;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    lane_d = req_addr[2:0];
                    rd_d   = req_rd;
                    if (misalign) begin
                        resp_valid_d    = 1'b1;
                        resp_rdata_d    = '0;
                        resp_rd_d       = req_rd;
                        resp_misalign_d = 1'b1;
                        state_d         = ST_RESP;
                    end else begin
                        mem_ena_d   = 1'b1;
                        mem_wen_d   = req_wen;
                        mem_mask_d  = size_onehot;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = wdata_repl;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mem_ena_d   = 1'b0;
                mem_wen_d   = 1'b0;
                mem_mask_d  = 4'b0000;
                mem_addr_d  = PARK_ADDR;
                mem_wdata_d = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                resp_valid_d    = 1'b1;
                resp_rdata_d    = wen_q ? '0 : load_ext;
                resp_rd_d       = rd_q;
                resp_misalign_d = 1'b0;
                state_d         = ST_RESP;
            end
            default: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wen_q           <= 1'b0;
            size_q          <= 2'd0;
            uns_q           <= 1'b0;
            lane_q          <= 3'd0;
            rd_q            <= 5'd0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_rd_q       <= 5'd0;
            resp_misalign_q <= 1'b0;
            mem_ena_q       <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_mask_q      <= 4'b0000;
            mem_addr_q      <= PARK_ADDR;
            mem_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            wen_q           <= wen_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            lane_q          <= lane_d;
            rd_q            <= rd_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_rd_q       <= resp_rd_d;
            resp_misalign_q <= resp_misalign_d;
            mem_ena_q       <= mem_ena_d;
            mem_wen_q       <= mem_wen_d;
            mem_mask_q      <= mem_mask_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_rd       = resp_rd_q;
    assign resp_misalign = resp_misalign_q;
    assign mem_ena       = mem_ena_q;
    assign mem_wen       = mem_wen_q;
    assign mem_mask      = mem_mask_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam logic [63:0] PARK = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_misalign;
    logic        mem_ena;
    logic        mem_wen;
    logic [3:0]  mem_mask;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_rd      (resp_rd),
        .resp_misalign(resp_misalign),
        .mem_ena      (mem_ena),
        .mem_wen      (mem_wen),
        .mem_mask     (mem_mask),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Drive a request at a negedge; returns just after the accept edge.
    task automatic send_req(input logic wen, input logic [1:0] size, input logic uns,
                            input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic consume_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (mem_ena !== 1'b0 || mem_addr !== PARK || mem_mask !== 4'b0 || mem_wdata !== 64'd0 || mem_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem: ena=%b addr=%h mask=%b wdata=%h wen=%b, expected 0/%h/0/0/0",
                     mem_ena, mem_addr, mem_mask, mem_wdata, mem_wen, PARK);
        end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_rd !== 5'd0 || resp_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: valid=%b rdata=%h rd=%0d mis=%b, expected all 0",
                     resp_valid, resp_rdata, resp_rd, resp_misalign);
        end
        @(negedge clk);
        rst = 1'b0;

        // Store, then reset in the middle of its ISSUE cycle.
        send_req(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'h1234_5678_9ABC_DEF0, 5'd3);
        @(negedge clk);
        n_checks++;
        if (mem_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_issue: mem_ena=%b, expected 1", mem_ena);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_ena !== 1'b0 || mem_addr !== PARK || mem_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_issue: ena=%b addr=%h wen=%b, expected 0/%h/0", mem_ena, mem_addr, mem_wen, PARK);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b resp_valid=%b ena=%b, expected 1/0/0", req_ready, resp_valid, mem_ena);
        end
    endtask

    task automatic test_store_byte();
        send_req(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'h0000_0000_0000_00AB, 5'd7);
        @(negedge clk);
        n_checks++;
        if (mem_ena !== 1'b1 || mem_wen !== 1'b1 || mem_mask !== 4'b1000 ||
            mem_wdata !== 64'hABAB_ABAB_ABAB_ABAB || mem_addr !== 64'h8000_0005 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL store_byte_issue: ena=%b wen=%b mask=%b wdata=%h addr=%h ready=%b, expected 1/1/1000/abababababababab/80000005/0",
                     mem_ena, mem_wen, mem_mask, mem_wdata, mem_addr, req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (mem_ena !== 1'b0 || mem_addr !== PARK || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_byte_wait: ena=%b addr=%h resp_valid=%b, expected 0/%h/0", mem_ena, mem_addr, resp_valid, PARK);
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'd0 || resp_rd !== 5'd7 || resp_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL store_byte_resp: valid=%b rdata=%h rd=%0d mis=%b, expected 1/0/7/0",
                     resp_valid, resp_rdata, resp_rd, resp_misalign);
        end
        consume_resp();
    endtask

    task automatic test_load_half();
        mem_rdata = 64'h0000_0000_8001_0000;
        send_req(1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'd0, 5'd9);
        @(negedge clk);
        n_checks++;
        if (mem_mask !== 4'b0100 || mem_wen !== 1'b0 || mem_addr !== 64'h8000_0002) begin
            n_fail++;
            $display("FAIL load_half_issue: mask=%b wen=%b addr=%h, expected 0100/0/80000002", mem_mask, mem_wen, mem_addr);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFF_FFFF_FFFF_8001 || resp_rd !== 5'd9) begin
            n_fail++;
            $display("FAIL load_half_signed: valid=%b rdata=%h rd=%0d, expected 1/ffffffffffff8001/9", resp_valid, resp_rdata, resp_rd);
        end
        consume_resp();

        send_req(1'b0, 2'd1, 1'b1, 64'h8000_0002, 64'd0, 5'd10);
        repeat (3) @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'h0000_0000_0000_8001) begin
            n_fail++;
            $display("FAIL load_half_unsigned: valid=%b rdata=%h, expected 1/0000000000008001", resp_valid, resp_rdata);
        end
        consume_resp();

        // Signed byte from the top lane.
        mem_rdata = 64'h80FF_0000_0000_0000;
        send_req(1'b0, 2'd0, 1'b0, 64'h8000_0007, 64'd0, 5'd11);
        repeat (3) @(negedge clk);
        n_checks++;
        if (resp_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            n_fail++;
            $display("FAIL load_byte_signed: rdata=%h, expected ffffffffffffff80", resp_rdata);
        end
        consume_resp();
    endtask

    task automatic test_load_word();
        int edges;
        mem_rdata = 64'h7FFF_FFFF_0000_0000;
        send_req(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 5'd12);
        edges = 1;
        while (resp_valid !== 1'b1 && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_checks++;
        if (edges != 3) begin
            n_fail++;
            $display("FAIL load_word_latency: resp_valid after %0d edges, expected 3", edges);
        end
        n_checks++;
        if (resp_rdata !== 64'h0000_0000_7FFF_FFFF || resp_rd !== 5'd12) begin
            n_fail++;
            $display("FAIL load_word_data: rdata=%h rd=%0d, expected 000000007fffffff/12", resp_rdata, resp_rd);
        end
        consume_resp();

        mem_rdata = 64'hFEDC_BA98_7654_3210;
        send_req(1'b0, 2'd3, 1'b1, 64'h8000_0008, 64'd0, 5'd13);
        repeat (3) @(negedge clk);
        n_checks++;
        if (resp_rdata !== 64'hFEDC_BA98_7654_3210) begin
            n_fail++;
            $display("FAIL load_double: rdata=%h, expected fedcba9876543210", resp_rdata);
        end
        consume_resp();
    endtask

    task automatic test_misalign();
        bit saw_ena = 1'b0;
        send_req(1'b0, 2'd2, 1'b0, 64'h8000_0006, 64'd0, 5'd14);
        if (mem_ena !== 1'b0) saw_ena = 1'b1;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_misalign !== 1'b1 || resp_rdata !== 64'd0 || resp_rd !== 5'd14) begin
            n_fail++;
            $display("FAIL misalign_resp: valid=%b mis=%b rdata=%h rd=%0d, expected 1/1/0/14",
                     resp_valid, resp_misalign, resp_rdata, resp_rd);
        end
        repeat (2) begin
            @(negedge clk);
            if (mem_ena !== 1'b0) saw_ena = 1'b1;
        end
        consume_resp();
        @(negedge clk);
        if (mem_ena !== 1'b0) saw_ena = 1'b1;
        n_checks++;
        if (saw_ena !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_no_mem: saw_ena=%b ready=%b, expected 0/1", saw_ena, req_ready);
        end

        // Misaligned half store: also must not touch memory.
        send_req(1'b1, 2'd1, 1'b0, 64'h8000_0003, 64'h55, 5'd15);
        n_checks++;
        if (resp_misalign !== 1'b1 || mem_ena !== 1'b0 || mem_addr !== PARK) begin
            n_fail++;
            $display("FAIL misalign_store: mis=%b ena=%b addr=%h, expected 1/0/%h", resp_misalign, mem_ena, mem_addr, PARK);
        end
        consume_resp();
    endtask

    task automatic test_backpressure();
        bit bad = 1'b0;
        mem_rdata = 64'h1122_3344_5566_7788;
        send_req(1'b0, 2'd2, 1'b1, 64'h8000_0000, 64'd0, 5'd21);
        repeat (2) @(posedge clk);
        #1;
        // Upstream presents and holds the next request while the response is stalled.
        req_wen      = 1'b0;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        req_addr     = 64'h8000_0026;
        req_rd       = 5'd22;
        req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== 64'h0000_0000_5566_7788 || resp_rd !== 5'd21 ||
                req_ready !== 1'b0 || mem_ena !== 1'b0) begin
                bad = 1'b1;
            end
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL backpressure_hold: valid=%b rdata=%h rd=%0d ready=%b ena=%b, expected 1/0000000055667788/21/0/0",
                     resp_valid, resp_rdata, resp_rd, req_ready, mem_ena);
        end
        consume_resp();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: ready=%b resp_valid=%b ena=%b, expected 1/0/0", req_ready, resp_valid, mem_ena);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_ena !== 1'b1 || mem_addr !== 64'h8000_0026 || mem_mask !== 4'b0100) begin
            n_fail++;
            $display("FAIL backpressure_next: ena=%b addr=%h mask=%b, expected 1/80000026/0100", mem_ena, mem_addr, mem_mask);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 64'h0000_0000_0000_1122 || resp_rd !== 5'd22) begin
            n_fail++;
            $display("FAIL backpressure_next_resp: valid=%b rdata=%h rd=%0d, expected 1/0000000000001122/22",
                     resp_valid, resp_rdata, resp_rd);
        end
        consume_resp();
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_wen      = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        req_rd       = 5'd0;
        resp_ready   = 1'b0;
        mem_rdata    = 64'd0;

        test_reset();
        test_store_byte();
        test_load_half();
        test_load_word();
        test_misalign();
        test_backpressure();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
